// File: rtl/sbox_share_ctrl.sv
// Host-side driver for a masked 4-bit Skinny S-box core: shares the input, runs the core until Synch, recombines.
// Optional macro SHARE_CTRL_TIMEOUT_EN adds a sticky err flag when the core never reports Synch.
module sbox_share_ctrl #(
    parameter int ORDER   = 4,
    parameter int FRESH_W = 210,
    parameter int LATENCY = 9,
    parameter int SLACK   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_data,
    input  logic [4*ORDER-1:0]     rand_in,
    input  logic [FRESH_W-1:0]     fresh_in,
    output logic [4*(ORDER+1)-1:0] sb_x,
    output logic [FRESH_W-1:0]     sb_fresh,
    output logic                   sb_rst,
    input  logic [4*(ORDER+1)-1:0] sb_y,
    input  logic                   sb_synch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_data,
    output logic                   busy,
    output logic                   err
);
    // Counter is wide enough to reach LATENCY+SLACK without wrapping.
    localparam int CNT_W = $clog2(LATENCY + SLACK + 2);

    typedef enum logic [1:0] {IDLE, CORE_RST, RUN, DONE} state_t;

    state_t                state_q, state_nx;
    logic [ORDER:0][3:0]   share_q, share_nx, split;
    logic [CNT_W-1:0]      cnt_q, cnt_nx;
    logic                  ov_q, ov_nx;
    logic [3:0]            od_q, od_nx, y_xor;
`ifdef SHARE_CTRL_TIMEOUT_EN
    logic                  err_q, err_nx;
`endif

    // Boolean sharing of the input and recombination of the core output.
    always_comb begin
        split    = '0;
        split[0] = in_data;
        for (int k = 1; k <= ORDER; k++) begin
            split[k] = rand_in[4*k-4 +: 4];
            split[0] = split[0] ^ rand_in[4*k-4 +: 4];
        end
        y_xor = '0;
        for (int k = 0; k <= ORDER; k++)
            y_xor = y_xor ^ sb_y[4*k +: 4];
    end

    always_comb begin
        state_nx = state_q;
        share_nx = share_q;
        cnt_nx   = cnt_q;
        ov_nx    = ov_q;
        od_nx    = od_q;
`ifdef SHARE_CTRL_TIMEOUT_EN
        err_nx   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    share_nx = split;
                    state_nx = CORE_RST;
                end
            end
            CORE_RST: begin
                cnt_nx   = '0;
                state_nx = RUN;
            end
            RUN: begin
                if (cnt_q != '1)
                    cnt_nx = cnt_q + 1'b1;
                // Synch in the first RUN cycle is left over from before the core restart.
                if (sb_synch && cnt_q != '0) begin
                    od_nx    = y_xor;
                    ov_nx    = 1'b1;
                    share_nx = '0;
                    state_nx = DONE;
                end
`ifdef SHARE_CTRL_TIMEOUT_EN
                else if (cnt_q == CNT_W'(LATENCY + SLACK)) begin
                    err_nx   = 1'b1;
                    share_nx = '0;
                    state_nx = IDLE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    ov_nx    = 1'b0;
                    od_nx    = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            share_q <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_nx;
            share_q <= share_nx;
            cnt_q   <= cnt_nx;
            ov_q    <= ov_nx;
            od_q    <= od_nx;
        end
    end

`ifdef SHARE_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_nx;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = rst && (state_q == IDLE);
    assign sb_rst    = (state_q != RUN);
    assign sb_fresh  = (state_q == RUN) ? fresh_in : '0;
    assign sb_x      = share_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl with a behavioural masked S-box core (fixed latency, random output masks).
module tb_sbox_share_ctrl;
    localparam int ORDER = 4;
    localparam int FW    = 210;
    localparam int LAT   = 9;
    localparam int SLK   = 4;
    localparam int SW    = 4*(ORDER+1);

    logic          clk, rst;
    logic          in_valid, in_ready, sb_rst, sb_synch, out_valid, out_ready, busy, err;
    logic [3:0]    in_data, out_data;
    logic [4*ORDER-1:0] rand_in, ymask;
    logic [FW-1:0] fresh_in, sb_fresh;
    logic [SW-1:0] sb_x, sb_y;

    int total = 0;
    int bad   = 0;
    int ccnt;
    logic stale, synch_kill;
    logic [3:0] exp_tab [16];

    sbox_share_ctrl #(.ORDER(ORDER), .FRESH_W(FW), .LATENCY(LAT), .SLACK(SLK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rand_in(rand_in), .fresh_in(fresh_in), .sb_x(sb_x), .sb_fresh(sb_fresh),
        .sb_rst(sb_rst), .sb_y(sb_y), .sb_synch(sb_synch), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] sbox(input logic [3:0] v);
        case (v)
            4'h0: sbox = 4'hC; 4'h1: sbox = 4'h6; 4'h2: sbox = 4'h9; 4'h3: sbox = 4'h0;
            4'h4: sbox = 4'h1; 4'h5: sbox = 4'hA; 4'h6: sbox = 4'h2; 4'h7: sbox = 4'hB;
            4'h8: sbox = 4'h3; 4'h9: sbox = 4'h8; 4'hA: sbox = 4'h5; 4'hB: sbox = 4'hD;
            4'hC: sbox = 4'h4; 4'hD: sbox = 4'hE; 4'hE: sbox = 4'h7; default: sbox = 4'hF;
        endcase
    endfunction

    function automatic logic [FW-1:0] rnd_fresh();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[32*i +: 32] = $urandom;
        return t[FW-1:0];
    endfunction

    // Behavioural core: counts cycles out of reset, raises Synch at LAT with freshly masked output shares.
    always_ff @(posedge clk) begin
        if (sb_rst) ccnt <= 0;
        else        ccnt <= ccnt + 1;
    end

    assign sb_synch = !sb_rst && !synch_kill && (ccnt == LAT || (stale && ccnt == 0));

    always_comb begin
        logic [3:0] xv, y0;
        xv = '0;
        for (int k = 0; k <= ORDER; k++) xv = xv ^ sb_x[4*k +: 4];
        y0 = sbox(xv);
        for (int k = 1; k <= ORDER; k++) y0 = y0 ^ ymask[4*k-4 +: 4];
        if (ccnt == 0) y0 = y0 ^ 4'h6;
        sb_y = {ymask, y0};
    end

    initial begin
        fresh_in = '0;
        forever begin
            @(posedge clk);
            #2 fresh_in = rnd_fresh();
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_txn(input logic [3:0] d, input logic [4*ORDER-1:0] m,
                          input logic [3:0] expv, input int hold);
        int n, cyc, syc;
        logic [SW-1:0] x0;
        logic [3:0] xs, od;
        logic hold_bad, run_bad;
        ymask    = 16'($urandom);
        in_data  = d;
        rand_in  = m;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept", 32'(n < 50), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        rand_in  = 16'($urandom);
        chk("ready_low", 32'(in_ready), 0);
        chk("busy", 32'(busy), 1);
        chk("core_rst", 32'(sb_rst), 1);
        @(negedge clk);
        x0 = sb_x;
        xs = '0;
        for (int k = 0; k <= ORDER; k++) xs = xs ^ x0[4*k +: 4];
        chk("x_xor", 32'(xs), 32'(d));
        chk("run_rst", 32'(sb_rst), 0);
        cyc = 2; syc = -1; run_bad = 1'b0;
        while (!out_valid && cyc < 60) begin
            if (sb_synch && cyc > 2) syc = cyc;
            if (sb_x !== x0 || sb_fresh !== fresh_in || busy !== 1'b1) run_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("run_stable", 32'(run_bad), 0);
        chk("latency", 32'(cyc), 32'(LAT + 3));
        chk("synch_to_valid", 32'(syc + 1), 32'(cyc));
        chk("out_data", 32'(out_data), 32'(expv));
        chk("x_clear", 32'(sb_x), 0);
        chk("fresh_done", 32'(sb_fresh == '0), 1);
        od = out_data;
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = ~d;
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== od || in_ready !== 1'b0 || busy !== 1'b1) hold_bad = 1'b1;
        end
        if (hold > 0) chk("done_hold", 32'(hold_bad), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ov_clr", 32'(out_valid), 0);
        chk("od_clr", 32'(out_data), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_ready", 32'(in_ready), 1);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_sb_rst"}, 32'(sb_rst), 1);
        chk({tag, "_sb_x"}, 32'(sb_x), 0);
        chk({tag, "_fresh"}, 32'(sb_fresh == '0), 1);
        chk({tag, "_ov"}, 32'(out_valid), 0);
        chk({tag, "_od"}, 32'(out_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        exp_tab = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                    4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};
        rst = 1'b0; in_valid = 1'b0; in_data = '0; rand_in = '0; out_ready = 1'b0;
        ymask = '0; stale = 1'b0; synch_kill = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 1);

        do_txn(4'h0, '0, 4'hC, 0);
        do_txn(4'h5, 16'($urandom), 4'hA, 0);
        do_txn(4'hF, 16'($urandom), 4'hF, 0);

        for (int v = 0; v < 16; v++) do_txn(4'(v), 16'($urandom), exp_tab[v], 0);

        do_txn(4'h9, 16'($urandom), 4'h8, 20);

        stale = 1'b1;
        do_txn(4'hA, 16'($urandom), 4'h5, 0);
        stale = 1'b0;

        // Abort in RUN counter 5 with an asynchronous reset.
        in_data = 4'h3; rand_in = 16'($urandom); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_run_rst", 32'(sb_rst), 0);
        #1 rst = 1'b0;
        #1 check_reset_outs("abort");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_txn(4'h3, 16'($urandom), 4'h0, 0);

        synch_kill = 1'b1;
        in_data = 4'h7; rand_in = 16'($urandom); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef SHARE_CTRL_TIMEOUT_EN
        begin
            int cyc;
            logic ov_seen;
            cyc = 1; ov_seen = 1'b0;
            while (!err && cyc < 60) begin
                if (out_valid) ov_seen = 1'b1;
                @(negedge clk);
                cyc++;
            end
            chk("to_cycle", 32'(cyc), 32'(LAT + SLK + 3));
            chk("to_err", 32'(err), 1);
            chk("to_busy", 32'(busy), 0);
            chk("to_x_clear", 32'(sb_x), 0);
            chk("to_no_ov", 32'(ov_seen | out_valid), 0);
            repeat (3) @(negedge clk);
            chk("to_err_sticky", 32'(err), 1);
        end
`else
        repeat (30) @(negedge clk);
        chk("wait_busy", 32'(busy), 1);
        chk("wait_sb_rst", 32'(sb_rst), 0);
        chk("wait_ov", 32'(out_valid), 0);
        chk("wait_err", 32'(err), 0);
`endif
        synch_kill = 1'b0;
        #1 rst = 1'b0;
        #1 check_reset_outs("final");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_txn(4'hE, 16'($urandom), 4'h7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
